branch_cond_unit: RTL and testbench

- Consumer side of the ALU flag interface.
- Holds the architectural flag register (S, Z, C, V, P), updated whenever the ALU asserts flag_up.
- Evaluates Bcc condition codes against the current or same-cycle-forwarded flags.
- Hands a registered taken/not-taken resolution with target PC to the fetch unit through a valid/ready handshake. Sits between the execute stage and the PC/fetch logic.

---
 rtl/branch_cond_unit.sv | 110 +++++++++++
 tb/tb_branch_cond_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: architectural flag register, Bcc condition evaluation with same-cycle
// flag forwarding, and a registered taken/not-taken resolution handed to fetch via valid/ready.
module branch_cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_alu_valid,
    input  logic             i_sf,
    input  logic             i_zf,
    input  logic             i_cf,
    input  logic             i_vf,
    input  logic             i_pf,
    input  logic             i_flag_up,
    input  logic             i_br_valid,
    output logic             o_br_ready,
    input  logic [3:0]       i_br_cond,
    input  logic [31:0]      i_br_target,
    input  logic [31:0]      i_br_fallthru,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_res_taken,
    output logic [31:0]      o_res_pc,
    output logic [4:0]       o_flags,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic [CNT_W-1:0] o_ntaken_cnt
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t           r_state;
    logic [4:0]       r_flags;
    logic             r_taken;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_ntaken_cnt;
    logic             w_alu_wr;
    logic [3:0]       w_eff;
    logic             w_s;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic             w_lt;
    logic             w_be;
    logic             w_cond;
    logic             w_accept;

    assign w_alu_wr = i_alu_valid & i_flag_up;
    // Parity is architectural state only, so it is left out of the evaluated flags.
    assign w_eff = w_alu_wr ? {i_sf, i_zf, i_cf, i_vf} : r_flags[4:1];
    assign {w_s, w_z, w_c, w_v} = w_eff;
    assign w_lt = w_s ^ w_v;
    assign w_be = w_c | w_z;

    always_comb begin
        case (i_br_cond)
            4'h0: w_cond = w_z;
            4'h1: w_cond = ~w_z;
            4'h2: w_cond = w_lt;
            4'h3: w_cond = w_lt | w_z;
            4'h4: w_cond = ~(w_lt | w_z);
            4'h5: w_cond = ~w_lt;
            4'h6: w_cond = w_c;
            4'h7: w_cond = w_be;
            4'h8: w_cond = ~w_be;
            4'h9: w_cond = ~w_c;
            4'hA: w_cond = w_s;
            4'hB: w_cond = ~w_s;
            4'hC: w_cond = w_v;
            4'hD: w_cond = ~w_v;
            4'hE: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign o_br_ready = (r_state == IDLE) | i_res_ready;
    assign w_accept   = i_br_valid & o_br_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_flags      <= '0;
            r_taken      <= 1'b0;
            r_pc         <= '0;
            r_taken_cnt  <= '0;
            r_ntaken_cnt <= '0;
        end else begin
            if (w_alu_wr)
                r_flags <= {i_sf, i_zf, i_cf, i_vf, i_pf};
            if (w_accept) begin
                r_state <= HOLD;
                r_taken <= w_cond;
                r_pc    <= w_cond ? i_br_target : i_br_fallthru;
                if (w_cond) begin
                    if (~&r_taken_cnt)
                        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
                end else if (~&r_ntaken_cnt) begin
                    r_ntaken_cnt <= r_ntaken_cnt + CNT_W'(1);
                end
            end else if (i_res_ready) begin
                r_state <= IDLE;
            end
        end
    end

    assign o_res_valid  = (r_state == HOLD);
    assign o_res_taken  = r_taken;
    assign o_res_pc     = r_pc;
    assign o_flags      = r_flags;
    assign o_taken_cnt  = r_taken_cnt;
    assign o_ntaken_cnt = r_ntaken_cnt;
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed vectors for branch_cond_unit; a second instance with
// 2-bit counters shares every input so counter saturation can be observed.
module tb_branch_cond_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, sf, zf, cf, vf, pf, flag_up;
    logic        br_valid, res_ready;
    logic [3:0]  br_cond;
    logic [31:0] br_target, br_fallthru;
    logic        br_ready, res_valid, res_taken;
    logic [31:0] res_pc;
    logic [4:0]  flags;
    logic [15:0] taken_cnt, ntaken_cnt;
    logic        s_br_ready, s_res_valid, s_res_taken;
    logic [31:0] s_res_pc;
    logic [4:0]  s_flags;
    logic [1:0]  s_taken_cnt, s_ntaken_cnt;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] masks [3] = '{16'h6AA9, 16'h64CE, 16'h5732};
    logic [4:0]  pats [3]  = '{5'b01000, 5'b10100, 5'b10011};
    logic [15:0] m;

    always #5 clk = ~clk;

    branch_cond_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_alu_valid(alu_valid), .i_sf(sf), .i_zf(zf), .i_cf(cf),
        .i_vf(vf), .i_pf(pf), .i_flag_up(flag_up), .i_br_valid(br_valid), .o_br_ready(br_ready),
        .i_br_cond(br_cond), .i_br_target(br_target), .i_br_fallthru(br_fallthru),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_taken(res_taken),
        .o_res_pc(res_pc), .o_flags(flags), .o_taken_cnt(taken_cnt), .o_ntaken_cnt(ntaken_cnt)
    );

    branch_cond_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .i_alu_valid(alu_valid), .i_sf(sf), .i_zf(zf), .i_cf(cf),
        .i_vf(vf), .i_pf(pf), .i_flag_up(flag_up), .i_br_valid(br_valid), .o_br_ready(s_br_ready),
        .i_br_cond(br_cond), .i_br_target(br_target), .i_br_fallthru(br_fallthru),
        .o_res_valid(s_res_valid), .i_res_ready(res_ready), .o_res_taken(s_res_taken),
        .o_res_pc(s_res_pc), .o_flags(s_flags), .o_taken_cnt(s_taken_cnt), .o_ntaken_cnt(s_ntaken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic up, input logic [4:0] f);
        alu_valid = v;
        flag_up   = up;
        {sf, zf, cf, vf, pf} = f;
    endtask

    task automatic br(input logic v, input logic [3:0] c, input logic [31:0] t, input logic [31:0] f);
        br_valid    = v;
        br_cond     = c;
        br_target   = t;
        br_fallthru = f;
    endtask

    initial begin
        rst_n = 1'b0;
        res_ready = 1'b0;
        alu(0, 0, 5'b0);
        br(0, 4'h0, 32'h0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_valid", 32'(res_valid), 32'h0);
        check("rst_taken_cnt", 32'(taken_cnt), 32'h0);
        check("rst_ntaken_cnt", 32'(ntaken_cnt), 32'h0);
        check("rst_br_ready", 32'(br_ready), 32'h1);

        alu(1, 1, 5'b01000);
        step();
        alu(0, 0, 5'b0);
        check("zwrite_flags", 32'(flags), 32'h08);
        br(1, 4'h0, 32'h100, 32'h14);
        step();
        check("eq_valid", 32'(res_valid), 32'h1);
        check("eq_taken", 32'(res_taken), 32'h1);
        check("eq_pc", res_pc, 32'h100);
        check("eq_taken_cnt", 32'(taken_cnt), 32'h1);
        br(0, 4'h0, 32'h0, 32'h0);
        res_ready = 1'b1;
        step();
        check("eq_drain_idle", 32'(res_valid), 32'h0);
        res_ready = 1'b0;

        alu(1, 1, 5'b10000);
        br(1, 4'h2, 32'h200, 32'h24);
        step();
        check("fwd_lt_taken", 32'(res_taken), 32'h1);
        check("fwd_lt_pc", res_pc, 32'h200);
        check("fwd_flags", 32'(flags), 32'h10);
        check("fwd_taken_cnt", 32'(taken_cnt), 32'h2);

        br(1, 4'hF, 32'h300, 32'h34);
        alu(1, 1, 5'b01000);
        #1;
        check("stall_br_ready", 32'(br_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("stall_valid_%0d", i), 32'(res_valid), 32'h1);
            check($sformatf("stall_taken_%0d", i), 32'(res_taken), 32'h1);
            check($sformatf("stall_pc_%0d", i), res_pc, 32'h200);
        end
        alu(0, 0, 5'b0);
        check("stall_taken_cnt", 32'(taken_cnt), 32'h2);
        check("stall_ntaken_cnt", 32'(ntaken_cnt), 32'h0);
        check("stall_flags", 32'(flags), 32'h08);
        res_ready = 1'b1;
        #1;
        check("release_br_ready", 32'(br_ready), 32'h1);
        step();
        check("queued_valid", 32'(res_valid), 32'h1);
        check("queued_taken", 32'(res_taken), 32'h0);
        check("queued_pc", res_pc, 32'h34);
        check("queued_ntaken_cnt", 32'(ntaken_cnt), 32'h1);
        br(0, 4'h0, 32'h0, 32'h0);
        step();
        check("queued_drain", 32'(res_valid), 32'h0);

        for (int i = 0; i < 4; i++) begin
            br(1, (i % 2) ? 4'hF : 4'hE, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
            step();
            check($sformatf("b2b_valid_%0d", i), 32'(res_valid), 32'h1);
            check($sformatf("b2b_taken_%0d", i), 32'(res_taken), (i % 2) ? 32'h0 : 32'h1);
            check($sformatf("b2b_pc_%0d", i), res_pc,
                  (i % 2) ? 32'h2000 + 32'(i * 16) : 32'h1000 + 32'(i * 16));
        end
        br(0, 4'h0, 32'h0, 32'h0);
        step();
        check("b2b_drain", 32'(res_valid), 32'h0);
        check("b2b_taken_cnt", 32'(taken_cnt), 32'h4);
        check("b2b_ntaken_cnt", 32'(ntaken_cnt), 32'h3);

        for (int i = 0; i < 5; i++) begin
            br(1, 4'hE, 32'h40, 32'h44);
            step();
        end
        br(0, 4'h0, 32'h0, 32'h0);
        step();
        check("sat_wide_taken", 32'(taken_cnt), 32'd9);
        check("sat_small_taken", 32'(s_taken_cnt), 32'h3);
        check("sat_small_ntaken", 32'(s_ntaken_cnt), 32'h3);

        for (int p = 0; p < 3; p++) begin
            alu(1, 1, pats[p]);
            step();
            alu(0, 0, 5'b0);
            check($sformatf("cc_flags_%0d", p), 32'(flags), 32'(pats[p]));
            m = masks[p];
            for (int c = 0; c < 16; c++) begin
                br(1, 4'(c), 32'h5000 + 32'(c), 32'h6000 + 32'(c));
                step();
                check($sformatf("cc_p%0d_c%0h", p, c), 32'(res_taken), 32'(m[c]));
            end
            br(0, 4'h0, 32'h0, 32'h0);
            step();
        end

        alu(1, 0, 5'b01000);
        br(1, 4'h0, 32'h700, 32'h74);
        step();
        alu(0, 0, 5'b0);
        check("noup_eq_taken", 32'(res_taken), 32'h0);
        check("noup_pc", res_pc, 32'h74);
        check("noup_flags", 32'(flags), 32'h13);

        res_ready = 1'b0;
        br(1, 4'hE, 32'h800, 32'h84);
        step();
        br(0, 4'h0, 32'h0, 32'h0);
        check("pre_rst_valid", 32'(res_valid), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("hold_rst_valid", 32'(res_valid), 32'h0);
        check("hold_rst_taken", 32'(res_taken), 32'h0);
        check("hold_rst_pc", res_pc, 32'h0);
        check("hold_rst_flags", 32'(flags), 32'h0);
        check("hold_rst_taken_cnt", 32'(taken_cnt), 32'h0);
        check("hold_rst_ntaken_cnt", 32'(ntaken_cnt), 32'h0);
        check("hold_rst_small_cnt", 32'({s_taken_cnt, s_ntaken_cnt}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
